div_rem_op: RTL and testbench

- Multi-cycle integer divide/remainder operator for the HLS operator library, one instance per LLVM udiv/sdiv/urem/srem instruction.
- Sits directly upstream of the cast stage: its registered `ret` feeds zext/sext/trunc operators.
- Iterative restoring divider, one quotient bit per enabled cycle, with a start/busy/done handshake the scheduler drives.

---
 rtl/div_op_pkg.sv | 46 ++++
 rtl/div_step.sv | 40 ++++
 rtl/div_rem_op.sv | 196 +++++++++++++++++++
 tb/tb_div_rem_op.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_op_pkg.sv
// Shared definitions for the iterative divide/remainder operator.
// Holds the FSM state type, the opcode constants (four ASCII characters
// packed into 32 bits) with opcode classification helpers, and the
// result-width adjustment rule that the cast stage also uses.
package div_op_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic [31:0] OP_UDIV = "udiv";
    localparam logic [31:0] OP_SDIV = "sdiv";
    localparam logic [31:0] OP_UREM = "urem";
    localparam logic [31:0] OP_SREM = "srem";

    function automatic logic is_signed_op(input logic [31:0] opcode);
        return (opcode == OP_SDIV) || (opcode == OP_SREM);
    endfunction

    function automatic logic is_rem_op(input logic [31:0] opcode);
        return (opcode == OP_UREM) || (opcode == OP_SREM);
    endfunction

    function automatic logic is_valid_op(input logic [31:0] opcode);
        return (opcode == OP_UDIV) || (opcode == OP_SDIV) ||
               (opcode == OP_UREM) || (opcode == OP_SREM);
    endfunction

    // Treat the low 'width' bits of value as the result and fill the upper
    // bits with its sign (signed ops) or zeros (unsigned ops). The caller
    // truncates to its return width, so narrowing is handled there.
    function automatic logic [63:0] sat_extend(input logic [63:0] value,
                                               input int          width,
                                               input logic        is_signed);
        logic [63:0] res;
        logic        fill;
        fill = is_signed ? value[width-1] : 1'b0;
        for (int i = 0; i < 64; i++) begin
            res[i] = (i < width) ? value[i] : fill;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_i     partial remainder (always < divisor for a non-zero divisor)
//   msb_i     next dividend bit shifted into the remainder
//   divisor_i divisor magnitude
//   rem_o     next partial remainder
//   qbit_o    quotient bit produced by this step
module div_step #(
    parameter int ParamBitWidth = 32
) (
    input  logic [ParamBitWidth-1:0] rem_i,
    input  logic                     msb_i,
    input  logic [ParamBitWidth-1:0] divisor_i,
    output logic [ParamBitWidth-1:0] rem_o,
    output logic                     qbit_o
);

    localparam int N = ParamBitWidth;

    logic         carry_s;
    logic [N-1:0] shifted_lo_s;
    logic [N-1:0] diff_s;

    // Shift-and-trial-subtract. The shifted remainder is N+1 bits wide; when
    // its top bit is set it exceeds any N-bit divisor, and the true difference
    // still fits in N bits, so the wrapped N-bit subtraction is exact.
    always_comb begin
        carry_s      = rem_i[N-1];
        shifted_lo_s = {rem_i[N-2:0], msb_i};
        diff_s       = shifted_lo_s - divisor_i;
        if (carry_s || (shifted_lo_s >= divisor_i)) begin
            qbit_o = 1'b1;
            rem_o  = diff_s;
        end else begin
            qbit_o = 1'b0;
            rem_o  = shifted_lo_s;
        end
    end

endmodule

// File: rtl/div_rem_op.sv
// Multi-cycle integer divide/remainder operator (udiv/sdiv/urem/srem).
// Restoring divider producing one quotient bit per enabled cycle; result is
// sign/zero-extended or truncated to ReturnBitWidth and held in 'ret'.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       global stall; all registers hold while low
//   start        request, accepted in IDLE when enable is high
//   lhs, rhs     dividend / divisor, sampled on accept
//   ret          registered result, held until the next done
//   busy         operation in flight
//   done         one-enabled-cycle result-valid pulse
//   div_by_zero  qualifies done: divisor was zero
module div_rem_op
    import div_op_pkg::*;
#(
    parameter logic [31:0] ParamOpCode    = OP_UDIV,
    parameter int          ParamBitWidth  = 32,
    parameter int          ReturnBitWidth = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic [ParamBitWidth-1:0]  lhs,
    input  logic [ParamBitWidth-1:0]  rhs,
    output logic [ReturnBitWidth-1:0] ret,
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero
);

    localparam int   N         = ParamBitWidth;
    localparam int   R         = ReturnBitWidth;
    localparam int   CW        = $clog2(N);
    localparam logic SIGNED_OP = is_signed_op(ParamOpCode);
    localparam logic REM_OP    = is_rem_op(ParamOpCode);
    localparam logic VALID_OP  = is_valid_op(ParamOpCode);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dvd_q, dvd_d;     // dividend, becomes the quotient bit by bit
    logic [N-1:0]  dvs_q, dvs_d;     // divisor magnitude
    logic [N-1:0]  rem_q, rem_d;     // partial remainder
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          zero_div_q, zero_div_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [R-1:0]  ret_q, ret_d;

    logic          accept_s;
    logic          lhs_neg_s, rhs_neg_s;
    logic [N-1:0]  lhs_mag_s, rhs_mag_s;
    logic [N-1:0]  step_rem_s;
    logic          step_qbit_s;
    logic [N-1:0]  quot_fix_s, rem_fix_s, sel_s;
    logic [63:0]   ext_s;

    div_step #(.ParamBitWidth(N)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[N-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .qbit_o    (step_qbit_s)
    );

    // An unrecognised opcode never leaves IDLE, so ret stays 0 and done never fires.
    assign accept_s = (state_q == IDLE) && start && VALID_OP;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = ITER;
                else          state_d = IDLE;
            end
            ITER: begin
                if (cnt_q == '0) state_d = FIX;
                else             state_d = ITER;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes and the sign-corrected, width-adjusted result.
    always_comb begin
        lhs_neg_s = SIGNED_OP && lhs[N-1];
        rhs_neg_s = SIGNED_OP && rhs[N-1];
        // |MIN| wraps to MIN, which the unsigned datapath reads as 2^(N-1).
        lhs_mag_s = lhs_neg_s ? -lhs : lhs;
        rhs_mag_s = rhs_neg_s ? -rhs : rhs;
        // A zero divisor yields an all-ones quotient; leaving it un-negated
        // gives -1 for sdiv. The remainder is |lhs| there, and the normal
        // dividend-sign correction turns it back into lhs for srem.
        if (q_neg_q && !zero_div_q) quot_fix_s = -dvd_q;
        else                        quot_fix_s = dvd_q;
        if (r_neg_q) rem_fix_s = -rem_q;
        else         rem_fix_s = rem_q;
        if (REM_OP) sel_s = rem_fix_s;
        else        sel_s = quot_fix_s;
        ext_s = sat_extend(64'(sel_s), N, SIGNED_OP);
    end

    // Output and datapath next-values per state.
    always_comb begin
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        zero_div_d = zero_div_q;
        busy_d     = busy_q;
        ret_d      = ret_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    dvd_d      = lhs_mag_s;
                    dvs_d      = rhs_mag_s;
                    rem_d      = '0;
                    cnt_d      = CW'(N - 1);
                    q_neg_d    = lhs_neg_s ^ rhs_neg_s;
                    r_neg_d    = lhs_neg_s;
                    zero_div_d = (rhs == '0);
                    busy_d     = 1'b1;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            ITER: begin
                rem_d = step_rem_s;
                dvd_d = {dvd_q[N-2:0], step_qbit_s};
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             cnt_d = cnt_q;
            end
            FIX: begin
                ret_d  = R'(ext_s);
                done_d = 1'b1;
                dbz_d  = zero_div_q;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; everything holds while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            zero_div_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ret_q      <= '0;
        end else if (enable) begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            zero_div_q <= zero_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            ret_q      <= ret_d;
        end
    end

    assign ret         = ret_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_rem_op.sv
// Bench for div_rem_op: six instances (udiv, sdiv, urem, srem at 32-bit
// return, sdiv at 64-bit return, and an unrecognised opcode) share one
// directed stimulus stream and are checked every cycle against a model that
// computes results with plain signed/unsigned arithmetic and a latency count.
module tb_div_rem_op;

    localparam int N = 32;
    localparam logic [31:0] OPS [4] = '{"udiv", "sdiv", "urem", "srem"};

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] lhs    = 32'd0;
    logic [31:0] rhs    = 32'd0;

    logic [31:0] ret32 [4];
    logic [63:0] ret64;
    logic [31:0] retx;
    logic [5:0]  done_w, busy_w, dbz_w;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        div_rem_op #(.ParamOpCode(OPS[g]), .ParamBitWidth(32), .ReturnBitWidth(32)) u_dut (
            .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
            .lhs(lhs), .rhs(rhs), .ret(ret32[g]), .busy(busy_w[g]),
            .done(done_w[g]), .div_by_zero(dbz_w[g]));
    end

    div_rem_op #(.ParamOpCode("sdiv"), .ParamBitWidth(32), .ReturnBitWidth(64)) u_sdiv64 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .lhs(lhs), .rhs(rhs), .ret(ret64), .busy(busy_w[4]),
        .done(done_w[4]), .div_by_zero(dbz_w[4]));

    div_rem_op #(.ParamOpCode("xdiv"), .ParamBitWidth(32), .ReturnBitWidth(32)) u_bad_op (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .lhs(lhs), .rhs(rhs), .ret(retx), .busy(busy_w[5]),
        .done(done_w[5]), .div_by_zero(dbz_w[5]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result: op 0 udiv, 1 sdiv, 2 urem, 3 srem.
    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            0: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            1: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2: return (b == 32'd0) ? a : a % b;
            default: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
        endcase
    endfunction

    // Behavioural model: a request seen while idle completes N+1 enabled edges later.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
    int          m_left = 0;
    logic [31:0] m_ret [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] p_ret [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [63:0] m_ret64 = 64'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
            for (int i = 0; i < 4; i++) m_ret[i] = 32'd0;
            m_ret64 = 64'd0;
        end else if (enable) begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dbz  = p_dbz;
                    for (int i = 0; i < 4; i++) m_ret[i] = p_ret[i];
                    m_ret64 = {{32{p_ret[1][31]}}, p_ret[1]};
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = N + 1;
                p_dbz  = (rhs == 32'd0);
                for (int i = 0; i < 4; i++) p_ret[i] = ref_op(i, lhs, rhs);
            end
        end
    end

    // Compare every DUT output against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("done[%0d]", i), 64'(done_w[i]), 64'(m_done));
                chk($sformatf("busy[%0d]", i), 64'(busy_w[i]), 64'(m_busy));
                chk($sformatf("dbz[%0d]", i),  64'(dbz_w[i]),  64'(m_dbz));
                chk($sformatf("ret[%0d]", i),  64'(ret32[i]),  64'(m_ret[i]));
            end
            chk("done64", 64'(done_w[4]), 64'(m_done));
            chk("busy64", 64'(busy_w[4]), 64'(m_busy));
            chk("dbz64",  64'(dbz_w[4]),  64'(m_dbz));
            chk("ret64",  ret64,          m_ret64);
            chk("badop_outs", {32'd0, retx}, 64'd0);
            chk("badop_flags", 64'({done_w[5], busy_w[5], dbz_w[5]}), 64'd0);
        end
    end

    // Issue one request and wait for done on the udiv instance. lat is the
    // number of clock edges from the accepting edge to the edge raising done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit stall,
                         input bit poke, input bit no_wait, output int lat);
        int cyc;
        bit seen;
        if (!no_wait) @(negedge clk);
        lhs   = a;
        rhs   = b;
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (poke && cyc == 10) begin start = 1'b1; lhs = 32'd999; rhs = 32'd3; end
            if (poke && cyc == 11) start = 1'b0;
            if (stall && cyc == 5)  enable = 1'b0;
            if (stall && cyc == 15) enable = 1'b1;
            if (done_w[0]) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'(cyc), 64'd0);
        lat = cyc - 1;
    endtask

    initial begin
        int lat;
        int dones;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        chk("reset_ret", 64'(ret32[0]), 64'd0);
        chk("reset_busy", 64'(busy_w[0]), 64'd0);

        // Pin the reference model against hand-computed values.
        chk("pin_udiv",    64'(ref_op(0, 32'd100, 32'd7)),          64'd14);
        chk("pin_sdiv",    64'(ref_op(1, 32'hFFFF_FF9C, 32'd7)),    64'hFFFF_FFF2);
        chk("pin_srem",    64'(ref_op(3, 32'hFFFF_FF9C, 32'd7)),    64'hFFFF_FFFE);
        chk("pin_ovf",     64'(ref_op(1, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h8000_0000);
        chk("pin_urem_dz", 64'(ref_op(2, 32'd5, 32'd0)),            64'd5);

        do_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, lat);
        chk("lat_udiv", 64'(lat), 64'd33);
        chk("udiv_100_7", 64'(ret32[0]), 64'd14);
        chk("urem_100_7", 64'(ret32[2]), 64'd2);
        chk("dbz_100_7", 64'(dbz_w[0]), 64'd0);

        do_op(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 1'b0, lat);
        chk("sdiv_m100_7", 64'(ret32[1]), 64'hFFFF_FFF2);
        chk("srem_m100_7", 64'(ret32[3]), 64'hFFFF_FFFE);
        chk("sdiv64_m100_7", ret64, 64'hFFFF_FFFF_FFFF_FFF2);

        do_op(32'd5, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        chk("lat_dz", 64'(lat), 64'd33);
        chk("udiv_5_0", 64'(ret32[0]), 64'hFFFF_FFFF);
        chk("urem_5_0", 64'(ret32[2]), 64'd5);
        chk("dbz_5_0", 64'(dbz_w[0]), 64'd1);

        do_op(32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0, lat);
        chk("sdiv_m5_0", 64'(ret32[1]), 64'hFFFF_FFFF);
        chk("srem_m5_0", 64'(ret32[3]), 64'hFFFF_FFFB);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, lat);
        chk("lat_stall", 64'(lat), 64'd43);
        chk("sdiv_ovf", 64'(ret32[1]), 64'h8000_0000);
        chk("srem_ovf", 64'(ret32[3]), 64'd0);

        // done must hold while stalled, then clear on the next enabled edge.
        do_op(32'd1000, 32'd10, 1'b0, 1'b0, 1'b0, lat);
        chk("udiv_1000_10", 64'(ret32[0]), 64'd100);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("done_held", 64'(done_w[0]), 64'd1);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("done_cleared", 64'(done_w[0]), 64'd0);

        do_op(32'd77, 32'd5, 1'b0, 1'b1, 1'b0, lat);
        chk("lat_poke", 64'(lat), 64'd33);
        chk("udiv_poke", 64'(ret32[0]), 64'd15);

        do_op(32'd200, 32'd9, 1'b0, 1'b0, 1'b0, lat);
        chk("udiv_200_9", 64'(ret32[0]), 64'd22);
        do_op(32'd50, 32'd6, 1'b0, 1'b0, 1'b1, lat);
        chk("lat_b2b", 64'(lat), 64'd33);
        chk("udiv_50_6", 64'(ret32[0]), 64'd8);

        // Reset mid-operation: outputs clear at once and no done follows.
        @(negedge clk);
        lhs = 32'd1000; rhs = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ret", 64'(ret32[0]), 64'd0);
        chk("rst_mid_busy", 64'(busy_w[0]), 64'd0);
        chk("rst_mid_ret64", ret64, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (45) begin
            @(negedge clk);
            if (done_w[0]) dones++;
        end
        chk("no_done_after_rst", 64'(dones), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
